// File: rtl/image_sched_pkg.sv
// Shared coprocessor definitions: scheduler state encoding, kernel-size limit
// and the configuration legality rule.
package image_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam int unsigned KER_MAX = 7;

    function automatic logic kernel_legal(input int unsigned k,
                                          input int unsigned cols,
                                          input int unsigned rows);
        return (k >= 1) && (k <= KER_MAX) && (k <= cols) && (k <= rows);
    endfunction

endpackage

// File: rtl/window_counter.sv
// Four nested sweep counters (r, c, kr, kc); holds when step_i is low and
// reports which levels are at their last value.
module window_counter
    import image_sched_pkg::*;
#(
    parameter int DIM_WIDTH = 10,
    parameter int KER_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 step_i,
    input  logic [DIM_WIDTH-1:0] cols_i,
    input  logic [DIM_WIDTH-1:0] rows_i,
    input  logic [KER_WIDTH-1:0] kernel_i,
    output logic [KER_WIDTH-1:0] kc_o,
    output logic                 wrap_kc_o,
    output logic                 wrap_kr_o,
    output logic                 wrap_c_o,
    output logic                 wrap_r_o
);

    logic [KER_WIDTH-1:0] kc_q, kr_q;
    logic [DIM_WIDTH-1:0] c_q, r_q;
    logic [KER_WIDTH-1:0] k_last;
    logic [DIM_WIDTH-1:0] c_last, r_last;

    assign k_last = kernel_i - KER_WIDTH'(1);
    assign c_last = cols_i - DIM_WIDTH'(kernel_i);
    assign r_last = rows_i - DIM_WIDTH'(kernel_i);

    assign kc_o      = kc_q;
    assign wrap_kc_o = (kc_q == k_last);
    assign wrap_kr_o = (kr_q == k_last);
    assign wrap_c_o  = (c_q == c_last);
    assign wrap_r_o  = (r_q == r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_q <= '0;
            kr_q <= '0;
            c_q  <= '0;
            r_q  <= '0;
        end else if (clr_i) begin
            kc_q <= '0;
            kr_q <= '0;
            c_q  <= '0;
            r_q  <= '0;
        end else if (step_i) begin
            // Innermost first: each level advances only when all inner levels wrap.
            if (!wrap_kc_o) begin
                kc_q <= kc_q + KER_WIDTH'(1);
            end else begin
                kc_q <= '0;
                if (!wrap_kr_o) begin
                    kr_q <= kr_q + KER_WIDTH'(1);
                end else begin
                    kr_q <= '0;
                    if (!wrap_c_o) begin
                        c_q <= c_q + DIM_WIDTH'(1);
                    end else begin
                        c_q <= '0;
                        r_q <= wrap_r_o ? '0 : r_q + DIM_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/image_sched.sv
// Sliding-window read scheduler: walks KxK windows over an image, issues one
// memory read per cycle (writes take priority) and tracks read-data latency.
module image_sched
    import image_sched_pkg::*;
#(
    parameter int MEM_AWIDTH  = 16,
    parameter int DIM_WIDTH   = 10,
    parameter int KER_WIDTH   = 3,
    parameter int MEM_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    input  logic [MEM_AWIDTH-1:0] cfg_base,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic [KER_WIDTH-1:0]  cfg_kernel,
    output logic                  cfg_err,
    input  logic                  wr_val,
    output logic                  mem_rd_val,
    output logic [MEM_AWIDTH-1:0] mem_rd_addr,
    output logic                  img_val,
    output logic                  img_last,
    output logic                  done
);

    // Reset asserts immediately but releases two clock edges after rst falls.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    sched_state_e          state_q;
    logic [DIM_WIDTH-1:0]  cols_q, rows_q;
    logic [KER_WIDTH-1:0]  kernel_q;
    logic [MEM_AWIDTH-1:0] rowr_q, win_q, ptr_q;
    logic [MEM_AWIDTH-1:0] cols_ext, rowr_nx, win_nx;
    logic                  accept, legal, step, rd_last_q;
    logic [KER_WIDTH-1:0]  kc;
    logic                  wrap_kc, wrap_kr, wrap_c, wrap_r;
    logic [MEM_LATENCY-1:0] vld_sr_q, last_sr_q;
    logic [MEM_LATENCY:0]   vld_chain, last_chain;

    assign accept   = (state_q == ST_IDLE) && cfg_val;
    assign legal    = kernel_legal(32'(cfg_kernel), 32'(cfg_cols), 32'(cfg_rows));
    assign step     = (state_q == ST_RUN) && !wr_val;
    assign cols_ext = MEM_AWIDTH'(cols_q);
    assign rowr_nx  = rowr_q + cols_ext;
    assign win_nx   = win_q + MEM_AWIDTH'(1);

    window_counter #(
        .DIM_WIDTH(DIM_WIDTH),
        .KER_WIDTH(KER_WIDTH)
    ) u_window_counter (
        .clk      (clk),
        .rst      (rst_int),
        .clr_i    (accept),
        .step_i   (step),
        .cols_i   (cols_q),
        .rows_i   (rows_q),
        .kernel_i (kernel_q),
        .kc_o     (kc),
        .wrap_kc_o(wrap_kc),
        .wrap_kr_o(wrap_kr),
        .wrap_c_o (wrap_c),
        .wrap_r_o (wrap_r)
    );

    // rowr = base + r*cols, win = rowr + c, ptr = win + kr*cols; address = ptr + kc.
    always_ff @(posedge clk) begin
        if (accept) begin
            cols_q   <= cfg_cols;
            rows_q   <= cfg_rows;
            kernel_q <= cfg_kernel;
            rowr_q   <= cfg_base;
            win_q    <= cfg_base;
            ptr_q    <= cfg_base;
        end else if (step && wrap_kc) begin
            if (!wrap_kr) begin
                ptr_q <= ptr_q + cols_ext;
            end else if (!wrap_c) begin
                win_q <= win_nx;
                ptr_q <= win_nx;
            end else if (!wrap_r) begin
                rowr_q <= rowr_nx;
                win_q  <= rowr_nx;
                ptr_q  <= rowr_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= ST_IDLE;
            cfg_rdy     <= 1'b1;
            cfg_err     <= 1'b0;
            mem_rd_val  <= 1'b0;
            mem_rd_addr <= '0;
            rd_last_q   <= 1'b0;
            done        <= 1'b0;
        end else begin
            cfg_err    <= 1'b0;
            mem_rd_val <= 1'b0;
            rd_last_q  <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            state_q <= ST_RUN;
                            cfg_rdy <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        mem_rd_val  <= 1'b1;
                        mem_rd_addr <= ptr_q + MEM_AWIDTH'(kc);
                        if (wrap_kc && wrap_kr && wrap_c && wrap_r) begin
                            rd_last_q <= 1'b1;
                            state_q   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (img_last) begin
                        done    <= 1'b1;
                        cfg_rdy <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-data latency tracking; chain bit 0 is the live strobe.
    assign vld_chain  = {vld_sr_q, mem_rd_val};
    assign last_chain = {last_sr_q, rd_last_q};

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            vld_sr_q  <= '0;
            last_sr_q <= '0;
        end else begin
            vld_sr_q  <= vld_chain[MEM_LATENCY-1:0];
            last_sr_q <= last_chain[MEM_LATENCY-1:0];
        end
    end

    assign img_val  = vld_chain[MEM_LATENCY];
    assign img_last = last_chain[MEM_LATENCY];

endmodule
